// File: rtl/pulse_meas.sv
// Two-channel pulse width/period measurement. Completed pulses become
// timestamped records queued in a show-ahead FIFO behind valid/ready.
module pulse_meas #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ena,
  input  logic [1:0]       pulse_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_chan,
  output logic [CNT_W-1:0] rec_width,
  output logic [CNT_W-1:0] rec_period,
  output logic [31:0]      rec_ts,
  output logic [7:0]       ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, LOW} state_t;

  typedef struct packed {
    logic             chan;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [31:0]      ts;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [1:0]       s1, s2, s3, rise, fall;
  logic [1:0]       sync_fill;
  logic [31:0]      ts;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] wcnt_q [2], wcnt_d [2];
  logic [CNT_W-1:0] pcnt_q [2], pcnt_d [2];
  logic [CNT_W-1:0] period_q [2], period_d [2];
  logic [31:0]      tsr_q [2], tsr_d [2];
  rec_t             new_rec [2];
  logic [1:0]       gen, load, drop, wr;
  logic [1:0]       ndrop;
  rec_t             pend_q [2];
  logic [1:0]       pend_vld;
  rec_t             mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, push, can_push;
  rec_t             push_rec, head;

  // Input synchronizer and timestamp. sync_fill keeps the FSMs from arming
  // on the reset-zeroed pipeline before it holds real samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      sync_fill <= '0;
      ts        <= '0;
    end else begin
      s1        <= pulse_in;
      s2        <= s1;
      s3        <= s2;
      sync_fill <= {sync_fill[0], 1'b1};
      if (clr)      ts <= '0;
      else if (ena) ts <= ts + 32'd1;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Per-channel measurement FSM
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      state_d[n]  = state_q[n];
      wcnt_d[n]   = wcnt_q[n];
      pcnt_d[n]   = pcnt_q[n];
      period_d[n] = period_q[n];
      tsr_d[n]    = tsr_q[n];
      gen[n]      = 1'b0;
      new_rec[n].chan   = (n == 1);
      new_rec[n].width  = wcnt_q[n];
      new_rec[n].period = period_q[n];
      new_rec[n].ts     = tsr_q[n];
      if (!ena) begin
        state_d[n] = WAIT_LOW;
        wcnt_d[n]  = '0;
        pcnt_d[n]  = '0;
      end else begin
        case (state_q[n])
          WAIT_LOW: if (sync_fill[1] && !s2[n]) state_d[n] = IDLE;
          IDLE: if (rise[n]) begin
            state_d[n]  = HIGH;
            wcnt_d[n]   = CNT_ONE;
            pcnt_d[n]   = CNT_ONE;
            tsr_d[n]    = ts;
            period_d[n] = '0;
          end
          HIGH: begin
            wcnt_d[n] = sat_inc(wcnt_q[n]);
            pcnt_d[n] = sat_inc(pcnt_q[n]);
            if (fall[n]) begin
              gen[n]     = 1'b1;
              state_d[n] = LOW;
            end
          end
          LOW: begin
            if (rise[n]) begin
              state_d[n]  = HIGH;
              period_d[n] = pcnt_q[n];
              wcnt_d[n]   = CNT_ONE;
              pcnt_d[n]   = CNT_ONE;
              tsr_d[n]    = ts;
            end else begin
              pcnt_d[n] = sat_inc(pcnt_q[n]);
            end
          end
          default: state_d[n] = WAIT_LOW;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n]  <= WAIT_LOW;
        wcnt_q[n]   <= '0;
        pcnt_q[n]   <= '0;
        period_q[n] <= '0;
        tsr_q[n]    <= '0;
      end
    end else if (clr) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n]  <= WAIT_LOW;
        wcnt_q[n]   <= '0;
        pcnt_q[n]   <= '0;
        period_q[n] <= '0;
        tsr_q[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        state_q[n]  <= state_d[n];
        wcnt_q[n]   <= wcnt_d[n];
        pcnt_q[n]   <= pcnt_d[n];
        period_q[n] <= period_d[n];
        tsr_q[n]    <= tsr_d[n];
      end
    end
  end

  // Pending registers and fixed-priority arbiter (channel 0 wins)
  always_comb begin
    pop      = rec_valid & rec_ready;
    can_push = ~full | pop;
    wr[0]    = pend_vld[0] & can_push;
    wr[1]    = pend_vld[1] & ~pend_vld[0] & can_push;
    push     = |wr;
    push_rec = pend_vld[0] ? pend_q[0] : pend_q[1];
    for (int n = 0; n < 2; n++) begin
      load[n] = gen[n] & (~pend_vld[n] | wr[n]);
      drop[n] = gen[n] & pend_vld[n] & ~wr[n];
    end
    ndrop = {1'b0, drop[0]} + {1'b0, drop[1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= '0;
      ovf_cnt  <= '0;
      for (int n = 0; n < 2; n++) pend_q[n] <= '0;
    end else if (clr) begin
      pend_vld <= '0;
      ovf_cnt  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (load[n]) begin
          pend_q[n]   <= new_rec[n];
          pend_vld[n] <= 1'b1;
        end else if (wr[n]) begin
          pend_vld[n] <= 1'b0;
        end
      end
      ovf_cnt <= sat_add8(ovf_cnt, ndrop);
    end
  end

  // Show-ahead record FIFO; a pop frees the slot a same-cycle push uses
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_rec;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign rec_valid  = ~empty;
  assign rec_chan   = head.chan;
  assign rec_width  = head.width;
  assign rec_period = head.period;
  assign rec_ts     = head.ts;
endmodule
